// File: rtl/muldiv_ctrl_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide sequencer.
// The master side issues operations; the slave side (the sequencer) returns stall and HI/LO results.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             hilo_write;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hilo_write, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hilo_write, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: 32-step shift-add multiply or restoring divide.
// Stalls the pipeline while running and writes HI/LO with a one-cycle strobe on completion.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  muldiv_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dq;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   divisor;
  logic               neg_q;
  logic               neg_r;

  logic               launch;
  logic               is_signed;
  logic               div_zero;
  logic               last;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_next;

  always_comb begin
    is_signed = ~bus.op[0];
    launch    = bus.start & ~bus.flush & ((state == IDLE) || (state == DONE));
    div_zero  = bus.op[1] & (bus.b == '0);
    abs_a     = (is_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (is_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    last      = (cnt == CW'(WIDTH - 1));
    acc_next  = mplier[0] ? acc + mcand : acc;
    prod      = neg_q ? -acc_next : acc_next;
    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    trial     = {rem, dq[WIDTH-1]};
    diff      = trial - {1'b0, divisor};
    quo_next  = {dq[WIDTH-2:0], ~diff[WIDTH]};
    rem_next  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (launch) begin
          if (!bus.op[1])    state_next = MUL;
          else if (div_zero) state_next = DONE;
          else               state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      MUL, DIV: if (last) state_next = DONE;
      default:  state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_comb begin
    bus.busy       = launch | (state == MUL) | (state == DIV);
    bus.done       = (state == DONE);
    bus.hilo_write = (state == DONE);
  end

  // Operand latch at launch, then one iteration per cycle; HI/LO load only on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      dq         <= '0;
      rem        <= '0;
      divisor    <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
    end else if (launch) begin
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      mcand   <= {{WIDTH{1'b0}}, abs_a};
      mplier  <= abs_b;
      dq      <= abs_a;
      divisor <= abs_b;
      neg_q   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r   <= is_signed & bus.op[1] & bus.a[WIDTH-1];
      if (div_zero) begin
        bus.hi_out <= bus.a;
        bus.lo_out <= '1;
      end
    end else if (!bus.flush) begin
      case (state)
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) {bus.hi_out, bus.lo_out} <= prod;
        end
        DIV: begin
          dq  <= quo_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.lo_out <= neg_q ? -quo_next : quo_next;
            bus.hi_out <= neg_r ? -rem_next : rem_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes model results, a negedge monitor pops and compares.
// Covers directed corner cases, flush, reset, back-to-back launches and randomized operations.
module tb_muldiv_ctrl;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   tests;
  int   failures;
  exp_t sb[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  // Reference arithmetic at 64-bit width; signed overflow falls out naturally.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb_, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = 64'(sa * sb_);
        hi = p[63:32];
        lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == OP_DIV) begin
          q  = sa / sb_;
          r  = sa % sb_;
          lo = q[31:0];
          hi = r[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Called just after a rising edge; start is held for exactly one cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit expect_result);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (expect_result) begin
      refModel(op, a, b, e.hi, e.lo);
      e.cyc = cycle + ((op[1] && b == 32'd0) ? 1 : 33);
      sb.push_back(e);
    end
    @(negedge clk);
    checkOutput("busy_at_launch", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic waitQueueEmpty();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b, 1'b1);
    waitQueueEmpty();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done || bus.hilo_write)
        checkOutput("hilo_write_eq_done", 64'(bus.hilo_write), 64'(bus.done));
      if (bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", 64'(cycle), 64'(e.cyc));
          checkOutput("hi_out", 64'(bus.hi_out), 64'(e.hi));
          checkOutput("lo_out", 64'(bus.lo_out), 64'(e.lo));
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end
    end
  end

  initial begin
    int c;
    int target;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    tests     = 0;
    failures  = 0;
    cycle     = 0;
    last_hi   = '0;
    last_lo   = '0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_hi", 64'(bus.hi_out), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo_out), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MULTU max x max with per-cycle busy profile.
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      checkOutput("busy_profile", 64'(bus.busy), (k <= 32) ? 64'd1 : 64'd0);
      @(posedge clk);
      #1;
    end
    waitQueueEmpty();

    runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    runOp(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    runOp(OP_DIV,  32'hFFFF_FFF9, 32'd2);
    runOp(OP_DIVU, 32'd7, 32'd2);
    runOp(OP_DIV,  32'd7, 32'hFFFF_FFFE);
    runOp(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    runOp(OP_DIVU, 32'h0000_1234, 32'd0);

    // Flush at cycle 10 of a running multiply.
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("flush_hi_kept", 64'(bus.hi_out), 64'(last_hi));
    checkOutput("flush_lo_kept", 64'(bus.lo_out), 64'(last_lo));

    // Asynchronous reset in the middle of cycle 15.
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 1'b0);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset_done", 64'(bus.done), 64'd0);
    checkOutput("midreset_hilo_write", 64'(bus.hilo_write), 64'd0);
    checkOutput("midreset_hi", 64'(bus.hi_out), 64'd0);
    checkOutput("midreset_lo", 64'(bus.lo_out), 64'd0);
    rst     = 1'b0;
    last_hi = '0;
    last_lo = '0;
    @(posedge clk);
    #1;

    // start and flush together in IDLE must not launch.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    checkOutput("start_flush_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("start_flush_no_launch", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;

    // Back-to-back: second op launched in the first op's DONE cycle.
    c = cycle;
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 1'b1);
    while (cycle < c + 33) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
    @(negedge clk);
    checkOutput("b2b_busy_second", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    waitQueueEmpty();

    // Randomized operations, sometimes chained from the DONE cycle.
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      applyStimulus(rop, ra, rb, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        target = sb[$].cyc;
        while (cycle < target) begin
          @(posedge clk);
          #1;
        end
      end else begin
        waitQueueEmpty();
      end
    end
    waitQueueEmpty();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
